// File: rtl/alu_pkg.sv
// alu_pkg -- shared types and constants for the alu_nzcv_seq block.
//   alu_op_e    : 3-bit opcode encoding of alu_ctrl
//   FLAG_*      : bit positions of N, Z, C, V inside the nzcv register
//   alu_state_e : sequencing FSM states (BUSY used only when ALU_MUL_EN is defined)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_ADC = 3'b100,
    OP_SBC = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- unsigned shift-add multiplier, one multiplier bit per cycle,
// keeping only the low WIDTH bits of the product.
//   clk, reset : clock, synchronous active-high reset (discards any operation)
//   start      : load operands a/b and begin (ignored while busy)
//   stall      : hold on the final iteration (consumer cannot take the product)
//   a, b       : operands sampled with start
//   busy       : an operation is in progress
//   done       : final iteration this cycle; product is valid
//   product    : low WIDTH bits of a*b, valid while done
// The last partial product is added combinationally so that the result is
// ready at the WIDTH-th edge after start.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start && !busy_q) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        // Final iteration: retire only once the product can be handed off.
        if (!stall) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end
      end else begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_nzcv_seq.sv
// alu_nzcv_seq -- registered ALU with an NZCV flag register and a
// valid/ready result interface.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operation request handshake
//   a, b, alu_ctrl      : operands and opcode (alu_pkg::alu_op_e)
//   set_flags           : write this operation's flags into nzcv
//   out_valid/out_ready : result handshake
//   res, nzcv           : registered result and flag register {N,Z,C,V}
// Build option: macro ALU_MUL_EN enables the iterative multiplier (opcode 111,
// WIDTH cycles). Without it, opcode 111 returns 0 in one cycle and leaves nzcv
// untouched.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting operations; single-cycle ops complete here
// BUSY    | multiplier iterating, in_ready low until the product retires
module alu_nzcv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       nzcv
);

  localparam int MSB = WIDTH - 1;

  alu_op_e          op;
  logic             accept;
  logic             out_free;
  logic             idle;
  logic             take_mul;

  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       nzcv_q, nzcv_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_out;
  logic             v_out;
  logic             flags_upd;
  logic [3:0]       flags_new;

  assign op       = alu_op_e'(alu_ctrl);
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = idle && !reset && out_free;
  assign accept   = in_valid && in_ready;

  // One adder serves ADD/SUB/ADC/SBC: subtraction is a + ~b + carry-in.
  always_comb begin
    b_eff = b;
    cin   = 1'b0;
    case (op)
      OP_SUB:  begin b_eff = ~b; cin = 1'b1; end
      OP_ADC:  cin = nzcv_q[FLAG_C];
      OP_SBC:  begin b_eff = ~b; cin = nzcv_q[FLAG_C]; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(cin);
  end

  always_comb begin
    alu_res   = '0;
    c_out     = 1'b0;
    v_out     = 1'b0;
    flags_upd = set_flags;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[MSB:0];
        c_out   = sum[WIDTH];
        v_out   = (a[MSB] == b_eff[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      // Reached only when the multiplier is not built: zero result, flags held.
      OP_MUL:  flags_upd = 1'b0;
      default: ;
    endcase
    flags_new         = '0;
    flags_new[FLAG_N] = alu_res[MSB];
    flags_new[FLAG_Z] = (alu_res == '0);
    flags_new[FLAG_C] = c_out;
    flags_new[FLAG_V] = v_out;
  end

`ifdef ALU_MUL_EN
  alu_state_e       state_q, state_d;
  logic             mul_sf_q, mul_sf_d;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign take_mul  = accept && (op == OP_MUL);
  assign mul_start = take_mul;
  assign idle      = (state_q == ST_IDLE) && !mul_busy;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .stall   (!out_free),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign take_mul = 1'b0;
  assign idle     = 1'b1;
`endif

  always_comb begin
    res_d       = res_q;
    nzcv_d      = nzcv_q;
    out_valid_d = out_valid_q && !out_ready;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mul_sf_d = mul_sf_q;
    if (take_mul) begin
      state_d  = ST_BUSY;
      mul_sf_d = set_flags;
    end
    // Retire only into a free output; otherwise the multiplier stalls.
    if (state_q == ST_BUSY && mul_done && out_free) begin
      res_d       = mul_product;
      out_valid_d = 1'b1;
      state_d     = ST_IDLE;
      if (mul_sf_q) begin
        nzcv_d[FLAG_N] = mul_product[MSB];
        nzcv_d[FLAG_Z] = (mul_product == '0);
      end
    end
`endif
    if (accept && !take_mul) begin
      res_d       = alu_res;
      out_valid_d = 1'b1;
      if (flags_upd) nzcv_d = flags_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      nzcv_q      <= 4'b0000;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      nzcv_q      <= nzcv_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mul_sf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mul_sf_q <= mul_sf_d;
    end
  end
`endif

  assign res       = res_q;
  assign out_valid = out_valid_q;
  assign nzcv      = nzcv_q;

endmodule
